// File: rtl/systolic_result_collector_pkg.sv
// Shared types and sizing helpers for the systolic array result collector.
package systolic_result_collector_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  // Index counter width for an N-entry row, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_result_collector_row_buf.sv
// One row's result buffer: reverse-order capture, completion flag, overrun detect, read port.
module collector_row_buf
  import systolic_result_collector_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned D_W_ACC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [D_W_ACC-1:0]    wr_data,
  input  logic                  clr,
  input  logic [cnt_w(N)-1:0]   rd_col,
  output logic [D_W_ACC-1:0]    rd_data_c,
  output logic                  row_done,
  output logic                  wc_nz_c,
  output logic                  ovr_c
);

  localparam int unsigned      CW       = cnt_w(N);
  localparam logic [CW-1:0]    LAST_IDX = CW'(N - 1);

  logic [D_W_ACC-1:0] mem [N];
  logic [CW-1:0]      wc;
  logic               done_eff_c;
  logic               wr_ok_c;
  logic [CW-1:0]      wr_idx_c;

  // A clear landing in the same cycle frees the row for the incoming word.
  always_comb begin
    done_eff_c = row_done && !clr;
    wr_ok_c    = wr_valid && !done_eff_c;
    ovr_c      = wr_valid && done_eff_c;
    wr_idx_c   = LAST_IDX - wc;
    wc_nz_c    = (wc != '0);
    rd_data_c  = mem[rd_col];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc       <= '0;
      row_done <= 1'b0;
    end else begin
      if (clr) row_done <= 1'b0;
      if (wr_ok_c) begin
        if (wc == LAST_IDX) begin
          wc       <= '0;
          row_done <= 1'b1;
        end else begin
          wc <= wc + CW'(1);
        end
      end
    end
  end

  // The edge PE's own sum arrives first, so the k-th word lands in column N-1-k.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_idx_c] <= wr_data;
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Collects per-row drain streams of an N x N systolic array and re-emits them row-major.
module systolic_result_collector
  import systolic_result_collector_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned D_W_ACC = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N*D_W_ACC-1:0]    in_data,
  input  logic [N-1:0]            in_valid,
  output logic [D_W_ACC-1:0]      m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_row_last,
  output logic                    m_last,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned   CW       = cnt_w(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t             state;
  logic [CW-1:0]      rd_row;
  logic [CW-1:0]      rd_col;
  logic [CW-1:0]      out_row;
  logic [N-1:0]       row_done;
  logic [N-1:0]       row_active;
  logic [N-1:0]       row_ovr;
  logic [N-1:0]       row_clr;
  logic [D_W_ACC-1:0] row_rd [N];
  logic               xfer_c;
  logic               load_c;

  assign xfer_c = m_valid && m_ready;

  for (genvar r = 0; r < N; r++) begin : g_row
    // The presented row is released when its last column is accepted.
    assign row_clr[r] = xfer_c && m_row_last && (out_row == CW'(r));

    collector_row_buf #(
      .N       (N),
      .D_W_ACC (D_W_ACC)
    ) u_row_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (in_valid[r]),
      .wr_data   (in_data[r*D_W_ACC +: D_W_ACC]),
      .clr       (row_clr[r]),
      .rd_col    (rd_col),
      .rd_data_c (row_rd[r]),
      .row_done  (row_done[r]),
      .wc_nz_c   (row_active[r]),
      .ovr_c     (row_ovr[r])
    );
  end

  // Load the next word whenever the output register is free and its row is complete.
  always_comb begin
    load_c = 1'b0;
    if (state == COLLECT) begin
      load_c = row_done[0];
    end else if (!(xfer_c && m_last) && (!m_valid || m_ready)) begin
      load_c = row_done[rd_row];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      rd_row     <= '0;
      rd_col     <= '0;
      out_row    <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_row_last <= 1'b0;
      m_last     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= overrun | (|row_ovr);
      if (load_c) begin
        state      <= DRAIN;
        m_valid    <= 1'b1;
        m_data     <= row_rd[rd_row];
        m_row_last <= (rd_col == LAST_IDX);
        m_last     <= (rd_col == LAST_IDX) && (rd_row == LAST_IDX);
        out_row    <= rd_row;
        if (rd_col == LAST_IDX) begin
          rd_col <= '0;
          rd_row <= (rd_row == LAST_IDX) ? '0 : rd_row + CW'(1);
        end else begin
          rd_col <= rd_col + CW'(1);
        end
      end else if ((state == DRAIN) && (!m_valid || m_ready)) begin
        m_valid    <= 1'b0;
        m_row_last <= 1'b0;
        m_last     <= 1'b0;
        if (xfer_c && m_last) state <= COLLECT;
      end
    end
  end

  assign busy = (state == DRAIN) || (|row_active) || (|row_done);

endmodule

// File: tb/tb_systolic_result_collector.sv
// Randomized scoreboard bench for the systolic result collector.
module tb_systolic_result_collector;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          rl;
    logic          l;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_row_last;
  logic            m_last;
  logic            busy;
  logic            overrun;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  int gaps     = 0;
  int ready_mode = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] mat [N][N];

  systolic_result_collector #(.N(N), .D_W_ACC(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_row_last (m_row_last),
    .m_last     (m_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_seq();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = DW'(N * r + c);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = {$urandom, $urandom};
  endtask

  // Expected readout is simply the matrix in row-major, column-ascending order.
  task automatic push_exp();
    exp_t e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        e.data = mat[r][c];
        e.rl   = (c == N - 1);
        e.l    = (r == N - 1) && (c == N - 1);
        exp_q.push_back(e);
      end
  endtask

  // Row r starts r*skew cycles late and emits its columns highest-first.
  task automatic feed(input int skew);
    int cycles;
    cycles = N + skew * (N - 1);
    for (int t = 0; t < cycles; t++) begin
      for (int r = 0; r < N; r++) begin
        int k;
        k = t - r * skew;
        if (k >= 0 && k < N) begin
          in_valid[r] = 1'b1;
          in_data[r*DW +: DW] = mat[r][N-1-k];
        end else begin
          in_valid[r] = 1'b0;
        end
      end
      cyc(1);
    end
    in_valid = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    cyc(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain_timeout remaining=%0d expected=0", name, exp_q.size());
    end
  endtask

  // Downstream ready generator.
  initial begin
    int pcnt;
    logic [3:0] pat;
    pat = 4'b1001;
    pcnt = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = pat[pcnt];
          pcnt = (pcnt + 1) % 4;
        end
        2: m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks hold-while-stalled and pops the scoreboard on each transfer.
  initial begin
    logic          prev_hold;
    logic [DW-1:0] prev_data;
    logic          prev_rl;
    logic          prev_l;
    logic          in_mat;
    exp_t          e;
    prev_hold = 1'b0;
    in_mat    = 1'b0;
    prev_data = '0;
    prev_rl   = 1'b0;
    prev_l    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        in_mat    = 1'b0;
      end else begin
        if (prev_hold) begin
          checks++;
          if (!(m_valid && m_data == prev_data && m_row_last == prev_rl && m_last == prev_l)) begin
            failures++;
            $display("FAIL hold actual=v%0b/%0h/%0b/%0b expected=v1/%0h/%0b/%0b",
                     m_valid, m_data, m_row_last, m_last, prev_data, prev_rl, prev_l);
          end
        end
        if (in_mat && !m_valid && m_ready) gaps++;
        if (m_valid) in_mat = 1'b1;
        if (m_valid && m_ready) begin
          checks++;
          xfers++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_word actual=%0h expected=none", m_data);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e.data || m_row_last !== e.rl || m_last !== e.l) begin
              failures++;
              $display("FAIL word actual=%0h/rl%0b/l%0b expected=%0h/rl%0b/l%0b",
                       m_data, m_row_last, m_last, e.data, e.rl, e.l);
            end
          end
          if (m_last) in_mat = 1'b0;
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
        prev_rl   = m_row_last;
        prev_l    = m_last;
      end
    end
  end

  initial begin
    int base;
    rst_n    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    cyc(3);
    chk("rst_m_valid", DW'(m_valid), '0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_row_last", DW'(m_row_last), '0);
    chk("rst_m_last", DW'(m_last), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_overrun", DW'(overrun), '0);
    rst_n = 1'b1;
    cyc(2);

    // Simultaneous rows, sequential values.
    fill_seq();
    push_exp();
    feed(0);
    wait_drain("single");
    chk("single_overrun", DW'(overrun), '0);
    chk("single_busy_idle", DW'(busy), '0);

    // Skewed rows as the array produces them: no bubbles after the first word.
    gaps = 0;
    fill_rand();
    push_exp();
    feed(1);
    wait_drain("skew");
    chk("skew_gaps", DW'(gaps), '0);

    // Stalling ready pattern 1,0,0,1.
    ready_mode = 1;
    fill_rand();
    push_exp();
    feed(1);
    wait_drain("stall");
    ready_mode = 0;
    cyc(2);

    // Back-to-back: second matrix row r arrives as first matrix row r is released.
    base = xfers;
    fill_seq();
    push_exp();
    feed(0);
    cyc(4);
    fill_rand();
    push_exp();
    feed(N);
    wait_drain("b2b");
    chk("b2b_words", DW'(xfers - base), DW'(2 * N * N));
    chk("b2b_overrun", DW'(overrun), '0);

    // Random ready and skew.
    ready_mode = 3;
    for (int i = 0; i < 3; i++) begin
      fill_rand();
      push_exp();
      feed($urandom_range(0, 2));
      wait_drain("random");
    end
    ready_mode = 0;
    chk("random_overrun", DW'(overrun), '0);

    // Overrun: refill row 2 while it is undrained and downstream stalls.
    ready_mode = 2;
    cyc(2);
    fill_seq();
    push_exp();
    feed(0);
    cyc(3);
    chk("ovr_before", DW'(overrun), '0);
    chk("ovr_stalled_valid", DW'(m_valid), DW'(1));
    for (int k = 0; k < N; k++) begin
      in_valid = 4'b0100;
      in_data[2*DW +: DW] = {$urandom, $urandom};
      cyc(1);
      if (k == 0) chk("ovr_set", DW'(overrun), DW'(1));
    end
    in_valid = '0;
    ready_mode = 0;
    wait_drain("overrun");
    chk("ovr_sticky", DW'(overrun), DW'(1));

    // Reset mid-drain, then a clean matrix.
    base = xfers;
    fill_rand();
    push_exp();
    feed(0);
    for (int n = 0; n < 100 && xfers < base + 6; n++) @(negedge clk);
    chk("mid_reset_progress", DW'(xfers - base), DW'(6));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_m_valid", DW'(m_valid), '0);
    chk("mid_rst_m_data", m_data, '0);
    chk("mid_rst_flags", DW'({m_row_last, m_last, busy}), '0);
    chk("mid_rst_overrun", DW'(overrun), '0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    fill_seq();
    push_exp();
    feed(0);
    wait_drain("post_reset");
    chk("post_reset_overrun", DW'(overrun), '0);
    chk("post_reset_busy", DW'(busy), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Sink end of the PE result-drain chain.
- Accepts the per-row out_data/out_valid streams from the edge PE of each row of an N x N systolic array. Buffers one full result matrix and re-emits it row-major, column-ascending, on a single valid/ready output stream for host/DMA readout.
- The array cannot be stalled, so the collector absorbs bursts at line rate and flags any overrun.

Parameters:
- N, 4, array dimension (rows = columns); result words per row.
- D_W_ACC, 64, accumulator/result word width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N*D_W_ACC  row r result word at bits [r*D_W_ACC +: D_W_ACC], from that row's edge PE.
- in_valid  in  N  bit r qualifies row r word; no backpressure.
- m_data  out  D_W_ACC  output result word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_row_last  out  1  high with column N-1 of each row.
- m_last  out  1  high with element (N-1,N-1) only.
- busy  out  1  matrix being collected or drained.
- overrun  out  1  sticky error; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, m_row_last=0, m_last=0, busy=0, overrun=0. All write counters, row-complete flags and read indices are 0. State is COLLECT.
- Capture is per row and independent:
  - Each row has an N-entry buffer and write count wc[r].
  - The k-th valid word of a row (k=0..N-1) is column N-1-k, because the edge PE's own sum arrives first.
  - When wc[r] reaches N, row_done[r] is set and wc[r] returns to 0.
  - Rows may finish in any order and in any relative skew.
- Overrun: in_valid[r] while row_done[r] is still set (row not yet drained).
  - The word is dropped and overrun is set the same cycle +1.
  - Buffer contents are unchanged.
- FSM, COLLECT -> DRAIN -> COLLECT:
  - COLLECT: m_valid=0. Go to DRAIN when row_done[0] is set.
  - DRAIN: present buffer[row][col], starting row=0, col=0.
  - Word handshake: a word transfers when m_valid && m_ready. On transfer, col increments. At col=N-1 it wraps to 0 and row increments, and row_done[row] clears on that same transfer.
  - Row not ready: if the next row's row_done is not yet set, m_valid drops until it is. Rows drain strictly in order 0..N-1.
  - Exit: after the transfer with m_last, return to COLLECT with row=0.
- Output register:
  - m_data, m_valid, m_row_last and m_last are registered outputs.
  - They hold stable while m_valid && !m_ready.
  - After a transfer, the next word appears on the next cycle, sustaining 1 word/cycle with m_ready held high.
- Latency: from the cycle row_done[0] sets to m_valid high is 1 cycle.
- Overlap with the next matrix:
  - A row may begin refilling in the cycle its row_done clears (its last word transferred).
  - A write and a clear in the same cycle are legal; the clear happens first.
- busy = (state==DRAIN) || any wc!=0 || any row_done.
- Widths: data passes through unmodified. Counters are $clog2(N) bits, with a minimum of 1 bit.
- rst_n asserted mid-drain or mid-collect aborts immediately to reset values. Partially captured data is discarded.

Decomposition:
- Shared package holds:
  - localparam helper for counter width CW = (N>1) ? $clog2(N) : 1.
  - FSM state enum {COLLECT, DRAIN}.
- One natural sub-module: collector_row_buf. Holds the N x D_W_ACC storage, reverse-index write counter, row_done flag, overrun detect and read port. It is instantiated N times via generate. The top holds the FSM, read indices and output register.

Test Plan:
- N=4, single matrix: rows fed simultaneously, row r words 4r+3,4r+2,4r+1,4r; m_ready=1 -> m_data 0..15 in 16 consecutive cycles. m_row_last on values 3,7,11,15; m_last only on 15; overrun=0.
- Skewed rows (row r starts r cycles late, as the array produces) -> same output order and values. m_valid has no gap after the first word.
- m_ready toggled 1,0,0,1 pattern during drain -> m_data/m_valid held while stalled; every word appears exactly once, in order.
- Overrun: refill row 2 with new values while row 2 is undrained and m_ready=0 -> overrun=1 one cycle later. Drained row 2 still shows the original values 8..11.
- Back-to-back matrices: second matrix row 0 arrives in the cycle row 0's last word transfers -> both matrices drain correctly (32 words); overrun=0.
- rst_n pulsed low mid-drain (after word 5) -> outputs zero asynchronously. A fresh matrix afterwards drains 0..15 normally.
